y_mat_addr_stream: RTL

//  Parametrised, sequential successor to the Y-matrix row-address lookup. It latches one packed

---
 rtl/y_mat_pkg.sv | 20 ++
 rtl/y_mat_field_sel.sv | 29 ++
 rtl/y_mat_addr_stream.sv | 112 +++++++++++
 3 files changed

// File: rtl/y_mat_pkg.sv
// Shared types and defaults for the Y-matrix row-address streamer.
// Holds the FSM state enum, default geometry and the row-to-entry map.
package y_mat_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int DEF_ENTRIES = 16;
    localparam int DEF_ENTRY_W = 16;
    localparam int DEF_FIELD_W = 10;
    localparam int DEF_ADDR_W  = 11;

    // Row 0 maps to the LSB entry; higher rows walk down from the top entry.
    function automatic int unsigned row_to_entry(input int unsigned row, input int unsigned entries);
        return (entries - row) % entries;
    endfunction

endpackage

// File: rtl/y_mat_field_sel.sv
// Combinational entry picker: selects the field addressed by a row out of a
// packed SRAM word and zero-extends it to the output address width.
module y_mat_field_sel
    import y_mat_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int ENTRY_W = DEF_ENTRY_W,
    parameter int FIELD_W = DEF_FIELD_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int ROW_W   = $clog2(ENTRIES)
) (
    input  logic [ENTRIES*ENTRY_W-1:0] word,
    input  logic [ROW_W-1:0]           row,
    output logic [ADDR_W-1:0]          addr
);

    logic [FIELD_W-1:0] fields [ENTRIES];
    logic [ROW_W-1:0]   entry_idx;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_field
            assign fields[gi] = word[gi*ENTRY_W +: FIELD_W];
        end
    endgenerate

    assign entry_idx = ROW_W'(row_to_entry(32'(row), ENTRIES));
    assign addr      = ADDR_W'(fields[entry_idx]);

endmodule

// File: rtl/y_mat_addr_stream.sv
// Latches one packed Y-matrix SRAM word and streams row addresses for a
// programmable run of rows over a valid/ready port, back-to-back capable.
module y_mat_addr_stream
    import y_mat_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int ENTRY_W = DEF_ENTRY_W,
    parameter int FIELD_W = DEF_FIELD_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                ld_valid,
    output logic                                ld_ready,
    input  logic [ENTRIES*ENTRY_W-1:0]          ld_data,
    input  logic [$clog2(ENTRIES)-1:0]          ld_start_row,
    input  logic [$clog2(ENTRIES):0]            ld_count,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [$clog2(ENTRIES)-1:0]          out_row,
    output logic [ADDR_W-1:0]                   out_addr1,
    output logic [ADDR_W-1:0]                   out_addr2,
    output logic                                out_last,
    output logic                                busy
);

    localparam int ROW_W = $clog2(ENTRIES);
    localparam logic [ROW_W:0] CNT_MAX = (ROW_W+1)'(ENTRIES);
    localparam logic [ROW_W:0] CNT_ONE = (ROW_W+1)'(1);

    state_t                     state_reg, state_next;
    logic [ENTRIES*ENTRY_W-1:0] word_reg, word_next;
    logic [ROW_W-1:0]           row_reg, row_next;
    logic [ROW_W:0]             remain_reg, remain_next;
    logic                       last_reg, last_next;
    logic [ADDR_W-1:0]          addr1_reg, addr2_reg;
    logic [ADDR_W-1:0]          sel_addr;
    logic [ROW_W:0]             cnt_sat;
    logic                       beat_accept;
    logic                       load;

    // Address is resolved from the values about to be latched so the payload
    // leaves straight from flops.
    y_mat_field_sel #(
        .ENTRIES (ENTRIES),
        .ENTRY_W (ENTRY_W),
        .FIELD_W (FIELD_W),
        .ADDR_W  (ADDR_W),
        .ROW_W   (ROW_W)
    ) u_field_sel (
        .word (word_next),
        .row  (row_next),
        .addr (sel_addr)
    );

    assign out_valid   = (state_reg == STREAM);
    assign busy        = (state_reg == STREAM);
    assign out_row     = row_reg;
    assign out_addr1   = addr1_reg;
    assign out_addr2   = addr2_reg;
    assign out_last    = last_reg;
    assign beat_accept = out_valid & out_ready;
    assign ld_ready    = (state_reg == IDLE) | (beat_accept & last_reg);
    assign load        = ld_valid & ld_ready;
    assign cnt_sat     = (ld_count > CNT_MAX) ? CNT_MAX : ld_count;

    always_comb begin
        state_next  = state_reg;
        word_next   = word_reg;
        row_next    = row_reg;
        remain_next = remain_reg;

        if (beat_accept) begin
            row_next    = row_reg + ROW_W'(1);
            remain_next = remain_reg - CNT_ONE;
            if (last_reg) begin
                state_next = IDLE;
            end
        end

        // A load landing on the final beat overrides the drain to IDLE.
        if (load && (cnt_sat != '0)) begin
            word_next   = ld_data;
            row_next    = ld_start_row;
            remain_next = cnt_sat;
            state_next  = STREAM;
        end

        last_next = (state_next == STREAM) && (remain_next == CNT_ONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            word_reg   <= '0;
            row_reg    <= '0;
            remain_reg <= '0;
            last_reg   <= 1'b0;
            addr1_reg  <= '0;
            addr2_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            word_reg   <= word_next;
            row_reg    <= row_next;
            remain_reg <= remain_next;
            last_reg   <= last_next;
            addr1_reg  <= sel_addr;
            addr2_reg  <= sel_addr + ADDR_W'(1);
        end
    end

endmodule
